// File: rtl/drone_pkg.sv
// Shared command codes, UART receiver state encoding and small helpers
// used by the drone command receiver and its UART front end.
package drone_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam logic [7:0] CMD_EMERGENCY = 8'h00;
  localparam logic [7:0] CMD_TAKEOFF   = 8'h01;
  localparam logic [7:0] CMD_LAND      = 8'h02;
  localparam logic [7:0] CMD_FORWARD   = 8'h03;
  localparam logic [7:0] CMD_BACKWARD  = 8'h04;
  localparam logic [7:0] CMD_LEFT      = 8'h05;
  localparam logic [7:0] CMD_RIGHT     = 8'h06;
  localparam logic [7:0] CMD_HOVER     = 8'h07;

  // Bit period in clock cycles, rounded to the nearest whole cycle.
  function automatic int bitPeriod(input int clkHz, input int baud);
    return (clkHz + baud / 2) / baud;
  endfunction

  function automatic logic needsArm(input logic [7:0] code);
    return (code >= CMD_LAND) && (code <= CMD_HOVER);
  endfunction

endpackage

// File: rtl/drone_cmd_rx_uart_rx.sv
// 8N1 UART receiver: synchronizes RxD, rejects start-bit glitches and
// reports either a one-cycle byte strobe or a one-cycle framing error.
module uart_rx
  import drone_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err
);

  localparam int DIV   = bitPeriod(CLK_HZ, BAUD);
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV + 1);
  localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] LAST_HALF = CNT_W'(HALF - 1);

  uart_state_e      state_q, state_d;
  logic             rxMeta_q, rxSync_q, rxPrev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bitIdx_q, bitIdx_d;
  logic [7:0]       shift_q, shift_d;
  logic             errHold_q, errHold_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  // Synchronizer and edge-history flops idle high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      rxMeta_q <= rxd;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= rxSync_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bitIdx_q  <= '0;
      shift_q   <= '0;
      errHold_q <= 1'b0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitIdx_q  <= bitIdx_d;
      shift_q   <= shift_d;
      errHold_q <= errHold_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitIdx_d  = bitIdx_q;
    shift_d   = shift_q;
    errHold_d = errHold_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rxPrev_q && !rxSync_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == LAST_HALF) begin
          cnt_d    = '0;
          bitIdx_d = '0;
          state_d  = rxSync_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == LAST_FULL) begin
          cnt_d    = '0;
          shift_d  = {rxSync_q, shift_q[7:1]};
          bitIdx_d = bitIdx_q + 3'd1;
          if (bitIdx_q == 3'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        // After a bad stop bit, wait for the line to idle before hunting for a new start.
        if (errHold_q) begin
          if (rxSync_q) begin
            errHold_d = 1'b0;
            state_d   = IDLE;
          end
        end else if (cnt_q == LAST_FULL) begin
          cnt_d = '0;
          if (rxSync_q) begin
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d    = 1'b1;
            errHold_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data       = shift_q;
  assign data_valid = valid_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/drone_cmd_rx.sv
// Drone command receiver: decodes UART command bytes into arm state and
// attitude/throttle setpoints, with a link-loss watchdog that levels the craft.
module drone_cmd_rx
  import drone_pkg::*;
#(
  parameter int                 CLK_HZ      = 50_000_000,
  parameter int                 BAUD        = 115200,
  parameter logic        [15:0] TAKEOFF_THR = 16'd3000,
  parameter logic signed [15:0] STEP        = 16'sd500,
  parameter int                 TIMEOUT_CYC = 50_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               RxD,
  output logic               cmd_valid,
  output logic        [7:0]  cmd_code,
  output logic               cmd_err,
  output logic               frame_err,
  output logic               armed,
  output logic        [15:0] throttle_sp,
  output logic signed [15:0] pitch_sp,
  output logic signed [15:0] roll_sp
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC);

  logic [7:0]         byteData;
  logic               byteValid;
  logic               armed_q, armed_d;
  logic [15:0]        thr_q, thr_d;
  logic signed [15:0] pitch_q, pitch_d;
  logic signed [15:0] roll_q, roll_d;
  logic [7:0]         code_q, code_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               wdExpired;

  uart_rx #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) uRx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (RxD),
    .data      (byteData),
    .data_valid(byteValid),
    .frame_err (frame_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
      thr_q   <= '0;
      pitch_q <= '0;
      roll_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      armed_q <= armed_d;
      thr_q   <= thr_d;
      pitch_q <= pitch_d;
      roll_q  <= roll_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  // Watchdog saturates at the limit so the levelling keeps applying until traffic returns.
  always_comb begin
    wd_d = wd_q;
    if (byteValid || !armed_q) wd_d = '0;
    else if (wd_q != WD_MAX)   wd_d = wd_q + 1'b1;
    wdExpired = armed_q && !byteValid && (wd_d == WD_MAX);
  end

  always_comb begin
    armed_d = armed_q;
    thr_d   = thr_q;
    pitch_d = pitch_q;
    roll_d  = roll_q;
    code_d  = code_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (byteValid) begin
      code_d = byteData;
      if ((byteData > CMD_HOVER) || (!armed_q && needsArm(byteData))) begin
        err_d = 1'b1;
      end else begin
        valid_d = 1'b1;
        case (byteData)
          CMD_EMERGENCY: begin
            armed_d = 1'b0;
            thr_d   = '0;
            pitch_d = '0;
            roll_d  = '0;
          end
          CMD_TAKEOFF: begin
            armed_d = 1'b1;
            thr_d   = TAKEOFF_THR;
            pitch_d = '0;
            roll_d  = '0;
          end
          CMD_LAND: begin
            armed_d = 1'b0;
            thr_d   = '0;
          end
          CMD_FORWARD: begin
            pitch_d = STEP;
            roll_d  = '0;
          end
          CMD_BACKWARD: begin
            pitch_d = -STEP;
            roll_d  = '0;
          end
          CMD_LEFT: begin
            roll_d  = -STEP;
            pitch_d = '0;
          end
          CMD_RIGHT: begin
            roll_d  = STEP;
            pitch_d = '0;
          end
          CMD_HOVER: begin
            pitch_d = '0;
            roll_d  = '0;
          end
          default: ;
        endcase
      end
    end else if (wdExpired) begin
      pitch_d = '0;
      roll_d  = '0;
    end
  end

  assign cmd_valid   = valid_q;
  assign cmd_err     = err_q;
  assign cmd_code    = code_q;
  assign armed       = armed_q;
  assign throttle_sp = thr_q;
  assign pitch_sp    = pitch_q;
  assign roll_sp     = roll_q;

endmodule

// File: tb/tb_drone_cmd_rx.sv
// Bench for drone_cmd_rx: directed command table, UART corner cases,
// watchdog timing, mid-frame reset and randomized traffic against a model.
module tb_drone_cmd_rx;

  localparam int BIT_CYC = 10;
  localparam int TMO     = 1000;
  localparam int THR     = 3000;
  localparam int STP     = 500;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               RxD = 1'b1;
  logic               cmd_valid;
  logic        [7:0]  cmd_code;
  logic               cmd_err;
  logic               frame_err;
  logic               armed;
  logic        [15:0] throttle_sp;
  logic signed [15:0] pitch_sp;
  logic signed [15:0] roll_sp;

  int nCompared = 0;
  int nMismatched = 0;
  int cyc = 0;
  int nValid = 0, nErr = 0, nFerr = 0;
  int lastValidCyc = 0;
  int startCyc = 0;

  int mArmed, mThr, mPitch, mRoll, mCode;

  typedef struct {
    logic [7:0] code;
    int expValid;
    int expErr;
    int expArmed;
    int expThr;
    int expPitch;
    int expRoll;
  } vec_t;

  vec_t vecs[14];

  drone_cmd_rx #(
    .CLK_HZ     (1_152_000),
    .BAUD       (115200),
    .TAKEOFF_THR(16'd3000),
    .STEP       (16'sd500),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RxD        (RxD),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .cmd_err    (cmd_err),
    .frame_err  (frame_err),
    .armed      (armed),
    .throttle_sp(throttle_sp),
    .pitch_sp   (pitch_sp),
    .roll_sp    (roll_sp)
  );

  // 868 time units per clock so a 10-cycle bit lasts 8680 units.
  always #434 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (cmd_valid) begin
      nValid++;
      lastValidCyc = cyc;
    end
    if (cmd_err) nErr++;
    if (frame_err) nFerr++;
  end

  initial begin
    #(868 * 90000);
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] code, input logic stopBit, input int gap);
    @(negedge clk);
    startCyc = cyc;
    RxD = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RxD = code[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    RxD = stopBit;
    repeat (BIT_CYC) @(negedge clk);
    RxD = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic checkState(input string name, input int eArmed, input int eThr,
                            input int ePitch, input int eRoll, input int eCode);
    checkOutput({name, ".armed"}, int'(armed), eArmed);
    checkOutput({name, ".throttle"}, int'(throttle_sp), eThr);
    checkOutput({name, ".pitch"}, int'(pitch_sp), ePitch);
    checkOutput({name, ".roll"}, int'(roll_sp), eRoll);
    checkOutput({name, ".code"}, int'(cmd_code), eCode);
  endtask

  task automatic sendAndCheck(input string name, input logic [7:0] code, input logic stopBit,
                              input int gap, input int eValid, input int eErr, input int eFerr,
                              input int eArmed, input int eThr, input int ePitch, input int eRoll,
                              input int eCode);
    int v0, e0, f0;
    v0 = nValid;
    e0 = nErr;
    f0 = nFerr;
    applyStimulus(code, stopBit, gap);
    checkOutput({name, ".validPulses"}, nValid - v0, eValid);
    checkOutput({name, ".errPulses"}, nErr - e0, eErr);
    checkOutput({name, ".ferrPulses"}, nFerr - f0, eFerr);
    checkState(name, eArmed, eThr, ePitch, eRoll, eCode);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, ".cmd_valid"}, int'(cmd_valid), 0);
    checkOutput({name, ".cmd_err"}, int'(cmd_err), 0);
    checkOutput({name, ".frame_err"}, int'(frame_err), 0);
    checkState(name, 0, 0, 0, 0, 0);
  endtask

  // Reference behaviour of one decoded byte, straight from the command rules.
  task automatic modelApply(input int code, output int eV, output int eE);
    eV = 0;
    eE = 0;
    mCode = code;
    if (code == 0) begin
      mArmed = 0; mThr = 0; mPitch = 0; mRoll = 0; eV = 1;
    end else if (code == 1) begin
      mArmed = 1; mThr = THR; mPitch = 0; mRoll = 0; eV = 1;
    end else if (code > 7 || mArmed == 0) begin
      eE = 1;
    end else begin
      eV = 1;
      case (code)
        2: begin mArmed = 0; mThr = 0; end
        3: begin mPitch = STP;  mRoll = 0; end
        4: begin mPitch = -STP; mRoll = 0; end
        5: begin mRoll = -STP;  mPitch = 0; end
        6: begin mRoll = STP;   mPitch = 0; end
        default: begin mPitch = 0; mRoll = 0; end
      endcase
    end
  endtask

  initial begin
    int v0, e0, f0, c0, eV, eE, rc, gap;
    logic [7:0] abortByte;

    vecs[0]  = '{8'h03, 0, 1, 0, 0,     0,    0};
    vecs[1]  = '{8'h55, 0, 1, 0, 0,     0,    0};
    vecs[2]  = '{8'h01, 1, 0, 1, 3000,  0,    0};
    vecs[3]  = '{8'h03, 1, 0, 1, 3000,  500,  0};
    vecs[4]  = '{8'h05, 1, 0, 1, 3000,  0,    -500};
    vecs[5]  = '{8'h04, 1, 0, 1, 3000,  -500, 0};
    vecs[6]  = '{8'h06, 1, 0, 1, 3000,  0,    500};
    vecs[7]  = '{8'h07, 1, 0, 1, 3000,  0,    0};
    vecs[8]  = '{8'h08, 0, 1, 1, 3000,  0,    0};
    vecs[9]  = '{8'h03, 1, 0, 1, 3000,  500,  0};
    vecs[10] = '{8'h02, 1, 0, 0, 0,     500,  0};
    vecs[11] = '{8'h06, 0, 1, 0, 0,     500,  0};
    vecs[12] = '{8'h01, 1, 0, 1, 3000,  0,    0};
    vecs[13] = '{8'h00, 1, 0, 0, 0,     0,    0};

    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkAllZero("afterReset");

    for (int i = 0; i < 14; i++) begin
      sendAndCheck($sformatf("vec%0d", i), vecs[i].code, 1'b1, 3, vecs[i].expValid,
                   vecs[i].expErr, 0, vecs[i].expArmed, vecs[i].expThr, vecs[i].expPitch,
                   vecs[i].expRoll, int'(vecs[i].code));
      if (i == 2) checkOutput("takeoffLatencyWithin10Bits", int'((lastValidCyc - startCyc) <= 10 * BIT_CYC), 1);
    end

    v0 = nValid; e0 = nErr; f0 = nFerr;
    @(negedge clk);
    RxD = 1'b0;
    #2000;
    RxD = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("glitch.validPulses", nValid - v0, 0);
    checkOutput("glitch.errPulses", nErr - e0, 0);
    checkOutput("glitch.ferrPulses", nFerr - f0, 0);

    sendAndCheck("badStop", 8'h01, 1'b0, 5, 0, 0, 1, 0, 0, 0, 0, 0);
    sendAndCheck("afterBadStop", 8'h01, 1'b1, 3, 1, 0, 0, 1, THR, 0, 0, 1);

    sendAndCheck("wdArm", 8'h03, 1'b1, 3, 1, 0, 0, 1, THR, STP, 0, 3);
    c0 = lastValidCyc;
    while (cyc < c0 + TMO - 1) @(negedge clk);
    checkOutput("wdBeforeLimit.pitch", int'(pitch_sp), STP);
    while (cyc < c0 + TMO) @(negedge clk);
    checkState("wdAtLimit", 1, THR, 0, 0, 3);
    while (cyc < c0 + TMO + 300) @(negedge clk);
    checkState("wdSaturated", 1, THR, 0, 0, 3);
    sendAndCheck("wdRecover", 8'h04, 1'b1, 3, 1, 0, 0, 1, THR, -STP, 0, 4);

    abortByte = 8'h03;
    v0 = nValid; e0 = nErr; f0 = nFerr;
    @(negedge clk);
    RxD = 1'b0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      RxD = abortByte[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    RxD = abortByte[4];
    repeat (BIT_CYC / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkAllZero("midFrameReset");
    RxD = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (120) @(negedge clk);
    checkOutput("abort.validPulses", nValid - v0, 0);
    checkOutput("abort.errPulses", nErr - e0, 0);
    checkOutput("abort.ferrPulses", nFerr - f0, 0);
    checkAllZero("afterAbort");
    sendAndCheck("afterAbortTakeoff", 8'h01, 1'b1, 3, 1, 0, 0, 1, THR, 0, 0, 1);

    mArmed = 1; mThr = THR; mPitch = 0; mRoll = 0; mCode = 1;
    for (int n = 0; n < 120; n++) begin
      rc = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) rc = $urandom_range(0, 255);
      gap = $urandom_range(1, 15);
      modelApply(rc, eV, eE);
      sendAndCheck($sformatf("rand%0d_code%0h", n, rc), 8'(rc), 1'b1, gap, eV, eE, 0,
                   mArmed, mThr, mPitch, mRoll, mCode);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
